// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - pipelined ALU with one-cycle ops and an optional shift-add multiplier
// Optional multiplier is enabled by defining ALU_PIPE_MUL_EN.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16,
    parameter int SH_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [IMM_W-1:0] imm,
    input  logic [SH_W-1:0]  sh,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             zero,
    output logic             illegal
);

`ifdef ALU_PIPE_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, MUL = 2'd2} state_t;
    localparam int CNT_W = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [CNT_W-1:0] cnt;
    logic             mul_done;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1} state_t;
`endif

    state_t state, state_nxt;

    logic             accept, out_xfer, is_mul;
    logic [WIDTH-1:0] alu_res, opb, sum, imm_sx, imm_zx;
    logic             alu_ovf, alu_ill;

    assign out_valid = (state == HOLD);
    assign out_xfer  = out_valid && out_ready;
    assign zero      = out_valid && (result == '0);
`ifdef ALU_PIPE_MUL_EN
    assign in_ready  = (state != MUL) && (!out_valid || out_ready);
    assign is_mul    = (op == 5'd8);
    assign mul_done  = (cnt == CNT_W'(WIDTH));
`else
    assign in_ready  = !out_valid || out_ready;
    assign is_mul    = 1'b0;
`endif
    assign accept    = in_valid && in_ready;

    assign imm_sx = WIDTH'(signed'(imm));
    assign imm_zx = WIDTH'(imm);

    // Shared adder: ADDI/ADD add, SUB adds the two's complement of in2.
    always_comb begin
        opb = in2;
        if (op == 5'd0)      opb = imm_sx;
        else if (op == 5'd2) opb = ~in2 + WIDTH'(1);
    end
    assign sum = in1 + opb;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (op)
            5'd0, 5'd1: begin
                alu_res = sum;
                alu_ovf = (in1[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
            end
            5'd2: begin
                alu_res = sum;
                alu_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
            end
            5'd3: alu_res = in1 | in2;
            5'd4: alu_res = in1 | imm_zx;
            5'd5: alu_res = in2 << sh;
            5'd6: alu_res = in2 >> sh;
            5'd7: alu_res = WIDTH'($signed(in1) >>> sh);
            default: alu_ill = !is_mul;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, HOLD: begin
                if (accept) begin
`ifdef ALU_PIPE_MUL_EN
                    state_nxt = is_mul ? MUL : HOLD;
`else
                    state_nxt = HOLD;
`endif
                end else if (out_xfer) begin
                    state_nxt = IDLE;
                end
            end
`ifdef ALU_PIPE_MUL_EN
            MUL: if (mul_done) state_nxt = HOLD;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result  <= '0;
            ovf     <= 1'b0;
            illegal <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
`endif
        end else if (accept && !is_mul) begin
            result  <= alu_res;
            ovf     <= alu_ovf;
            illegal <= alu_ill;
`ifdef ALU_PIPE_MUL_EN
        end else if (accept) begin
            acc     <= '0;
            mcand   <= in1;
            mplier  <= in2;
            cnt     <= '0;
        end else if (state == MUL) begin
            // One multiplier bit per cycle; the extra cycle after WIDTH steps publishes acc.
            if (mul_done) begin
                result  <= acc;
                ovf     <= 1'b0;
                illegal <= 1'b0;
            end else begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CNT_W'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] in1, in2;
    logic [15:0] imm;
    logic [4:0]  sh;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        ovf, zero, illegal;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(32), .IMM_W(16), .SH_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .in1(in1), .in2(in2), .imm(imm), .sh(sh),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .ovf(ovf), .zero(zero), .illegal(illegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request, let it be accepted on the next edge, sample 1 time unit later.
    task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] i, input logic [4:0] s);
        op = o; in1 = a; in2 = b; imm = i; sh = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] r, input logic v,
                           input logic z, input logic il);
        chk({tag, ".valid"}, 64'(out_valid), 64'(1'b1));
        chk({tag, ".result"}, 64'(result), 64'(r));
        chk({tag, ".ovf"}, 64'(ovf), 64'(v));
        chk({tag, ".zero"}, 64'(zero), 64'(z));
        chk({tag, ".illegal"}, 64'(illegal), 64'(il));
    endtask

    initial begin
        logic [31:0] held;
        int lat;
        logic seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; in1 = '0; in2 = '0; imm = '0; sh = '0;
        #1;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.result", 64'(result), 64'd0);
        chk("rst.flags", 64'({ovf, zero, illegal}), 64'd0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst.in_ready", 64'(in_ready), 64'd1);

        issue(5'd1, 32'h7FFF_FFFF, 32'h1, 16'h0, 5'd0);
        chk_out("add_ovf", 32'h8000_0000, 1'b1, 1'b0, 1'b0);
        issue(5'd0, 32'd5, 32'h0, 16'hFFFB, 5'd0);
        chk_out("addi_zero", 32'h0, 1'b0, 1'b1, 1'b0);
        issue(5'd4, 32'h0, 32'h0, 16'h8000, 5'd0);
        chk_out("ori", 32'h0000_8000, 1'b0, 1'b0, 1'b0);
        issue(5'd7, 32'h8000_0000, 32'h0, 16'h0, 5'd4);
        chk_out("sra", 32'hF800_0000, 1'b0, 1'b0, 1'b0);
        issue(5'd6, 32'h0, 32'h8000_0000, 16'h0, 5'd4);
        chk_out("shr", 32'h0800_0000, 1'b0, 1'b0, 1'b0);
        issue(5'd2, 32'h8000_0000, 32'h1, 16'h0, 5'd0);
        chk_out("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0);
        issue(5'd5, 32'h0, 32'h1, 16'h0, 5'd31);
        chk_out("shl", 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        issue(5'd3, 32'h0000_00F0, 32'h0000_000F, 16'h0, 5'd0);
        chk_out("or", 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
        issue(5'd9, 32'h1234, 32'h5678, 16'h0, 5'd0);
        chk_out("op9_illegal", 32'h0, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("drain.out_valid", 64'(out_valid), 64'd0);

        // Back-to-back ADDs, one result per cycle.
        in_valid = 1'b1; op = 5'd1; in2 = 32'd1;
        for (int k = 0; k < 4; k++) begin
            in1 = 32'(k * 10);
            @(posedge clk); #1;
            chk("b2b.valid", 64'(out_valid), 64'd1);
            chk("b2b.result", 64'(result), 64'(k * 10 + 1));
        end
        held = result;

        // Stall: pending request must wait, held result must not move.
        out_ready = 1'b0; in1 = 32'd100; in2 = 32'd200;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("stall.in_ready", 64'(in_ready), 64'd0);
            chk("stall.valid", 64'(out_valid), 64'd1);
            chk("stall.result", 64'(result), 64'(held));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk_out("stall_release", 32'd300, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("idle.out_valid", 64'(out_valid), 64'd0);

`ifdef ALU_PIPE_MUL_EN
        issue(5'd8, 32'hFFFF_FFFD, 32'd7, 16'h0, 5'd0);
        in1 = 32'hDEAD_BEEF; in2 = 32'h1234_5678;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (out_valid) break;
            chk("mul.in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
            lat = k;
        end
        chk("mul.latency", 64'(lat), 64'd33);
        chk_out("mul", 32'hFFFF_FFEB, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;

        issue(5'd8, 32'hFFFF_FFFD, 32'd7, 16'h0, 5'd0);
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mulrst.out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mulrst.in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("mulrst.never_valid", 64'(seen), 64'd0);
`else
        issue(5'd8, 32'd3, 32'd7, 16'h0, 5'd0);
        chk_out("op8_illegal", 32'h0, 1'b0, 1'b1, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, data path width in bits (legal 8..64).
REQ-002 Parameter IMM_W, default 16, immediate width (legal 1..WIDTH).
REQ-003 Parameter SH_W, default 5, shift-amount width; SH_W SHALL equal ceil(log2(WIDTH)).
REQ-004 Port clk  input  1  single rising-edge clock for all state.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port in_valid  input  1  operation request present.
REQ-007 Port in_ready  output  1  block accepts a request this cycle.
REQ-008 Port op  input  5  opcode; 0 ADDI, 1 ADD, 2 SUB, 3 OR, 4 ORI, 5 SHL, 6 SHR, 7 SRA, 8 MUL.
REQ-009 Port in1  input  WIDTH  operand A, two's complement.
REQ-010 Port in2  input  WIDTH  operand B, two's complement.
REQ-011 Port imm  input  IMM_W  immediate.
REQ-012 Port sh  input  SH_W  shift amount.
REQ-013 Port out_valid  output  1  result/flags valid.
REQ-014 Port out_ready  input  1  consumer takes the result this cycle.
REQ-015 Port result  output  WIDTH  registered result.
REQ-016 Port ovf  output  1  signed overflow of ADDI/ADD/SUB; 0 for other ops.
REQ-017 Port zero  output  1  result equals 0.
REQ-018 Port illegal  output  1  opcode was outside the compiled-in set; result forced to 0.

Function
REQ-019 States SHALL be IDLE, MUL, HOLD; transfer occurs on in_valid&&in_ready (input) and out_valid&&out_ready (output).
REQ-020 in_ready SHALL be 1 iff state!=MUL and (out_valid==0 or out_ready==1), combinationally.
REQ-021 Ops 0-7 and illegal opcodes SHALL complete in 1 cycle: result registered on the accepting edge, out_valid=1 next cycle, state HOLD.
REQ-022 Throughput for single-cycle ops SHALL be one per cycle when out_ready is held 1.
REQ-023 ADDI: in1 + sign-extended imm; ORI: in1 | zero-extended imm.
REQ-024 ADD/SUB: in1+in2 / in1-in2 modulo 2^WIDTH; ovf set when operand signs make the WIDTH-bit signed result wrap.
REQ-025 OR: in1|in2; SHL: in2<<sh; SHR: in2>>sh logical; SRA: in1>>>sh arithmetic.
REQ-026 MUL accepted in IDLE/HOLD SHALL enter MUL, iterate shift-add one bit per cycle for exactly WIDTH cycles, then load low WIDTH bits of in1*in2 into result and enter HOLD with out_valid=1.
REQ-027 MUL latency from accept edge to out_valid=1 SHALL be WIDTH+1 cycles; in_ready=0 throughout MUL.
REQ-028 Operands SHALL be captured on accept; later input changes do not affect the operation in flight.
REQ-029 In HOLD with out_ready=0, result/flags/out_valid SHALL stay stable.
REQ-030 In HOLD, output transfer without a new accept SHALL return to IDLE with out_valid=0; simultaneous output transfer and accept SHALL load the new operation in the same edge.
REQ-031 zero SHALL be computed from the registered result.

Reset
REQ-032 rst=1 SHALL immediately force state IDLE, out_valid=0, result=0, ovf=0, zero=0, illegal=0, multiplier accumulator/counter=0.
REQ-033 Reset during MUL SHALL abort the multiply with no result ever presented.
REQ-034 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-035 Macro ALU_PIPE_MUL_EN: defined -> opcode 8 is MUL per REQ-026/027; undefined -> no MUL state or multiplier logic, opcode 8 handled as illegal (1 cycle, result 0, illegal=1).

Verification
REQ-036 WIDTH=32: ADD in1=0x7FFFFFFF, in2=1 -> result 0x80000000, ovf=1, zero=0, out_valid next cycle.
REQ-037 ADDI in1=5, imm=0xFFFB -> result 0, zero=1; ORI in1=0, imm=0x8000 -> result 0x00008000.
REQ-038 SRA in1=0x80000000, sh=4 -> 0xF8000000; SHR in2=0x80000000, sh=4 -> 0x08000000.
REQ-039 MUL_EN defined: MUL in1=-3, in2=7 -> result 0xFFFFFFEB after 33 cycles, in_ready=0 during; rst asserted at cycle 10 -> out_valid never rises, in_ready=1 after release.
REQ-040 Back-to-back ADDs with out_ready=1 -> one result per cycle; out_ready=0 for 3 cycles -> result held stable, in_ready=0, no loss.
REQ-041 op=9 (and op=8 with MUL_EN undefined) -> result 0, illegal=1, 1-cycle latency.
